// File: rtl/ps2_led_cmd_ctrl.sv
// PS/2 host-to-device "Set LEDs" sequencer: sends 0xED then the LED byte, each acknowledged with 0xFA.
// busy rises 1 cycle after led_req; requests while busy are dropped, and the PS/2 device paces the bit transfer.
module ps2_led_cmd_ctrl #(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int MAX_RETRY      = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       led_req,
   input  logic [2:0] led_val,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   input  logic       rx_ready,
   input  logic [9:0] rx_code,
   output logic       rx_rst_n
);

   localparam int IW = $clog2(INHIBIT_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int RW = $clog2(MAX_RETRY + 2);

   localparam logic [IW-1:0] INH_LAST  = IW'(INHIBIT_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

   localparam logic [9:0] CODE_ACK    = 10'h0FA;
   localparam logic [9:0] CODE_RESEND = 10'h0FE;
   localparam logic [7:0] CMD_SET_LED = 8'hED;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_START,
      S_TX,
      S_REL,
      S_RESP,
      S_DONE,
      S_ERR
   } state_t;

   state_t        state;
   logic [IW-1:0] inh_cnt;
   logic [TW-1:0] to_cnt;
   logic [RW-1:0] retry;
   logic [RW-1:0] retry_nxt;
   logic [3:0]    bit_cnt;
   logic          byte_idx;
   logic [2:0]    led_q;

   logic clk_s1, clk_s2, clk_prev;
   logic dat_s1, dat_s2;
   logic clk_fall;

   logic [7:0] tx_byte;
   logic       tx_parity;
   logic       active;
   logic       to_hit;
   logic       fail;
   logic [1:0] fail_code;
   logic       go_inh;
   logic       go_done;

   // Synchronizers idle high so a released bus never produces a false falling edge
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         clk_prev <= 1'b1;
         dat_s1   <= 1'b1;
         dat_s2   <= 1'b1;
      end else begin
         clk_s1   <= ps2_clk_in;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         dat_s1   <= ps2_data_in;
         dat_s2   <= dat_s1;
      end
   end

   assign clk_fall  = clk_prev & ~clk_s2;
   assign tx_byte   = byte_idx ? {5'b0, led_q} : CMD_SET_LED;
   assign tx_parity = ~^tx_byte;
   assign retry_nxt = retry + RW'(1);
   assign active    = (state == S_START) || (state == S_TX) ||
                      (state == S_REL)   || (state == S_RESP);
   assign to_hit    = active && (to_cnt == TO_LAST);

   always_comb begin
      fail      = 1'b0;
      fail_code = 2'd0;
      go_inh    = 1'b0;
      go_done   = 1'b0;
      case (state)
         S_IDLE: go_inh = led_req;
         S_TX: begin
            if (clk_fall && (bit_cnt == 4'd10) && dat_s2) begin
               fail      = 1'b1;
               fail_code = 2'd2;
            end
         end
         S_RESP: begin
            if (rx_ready) begin
               if (rx_code == CODE_ACK) begin
                  go_done = byte_idx;
                  go_inh  = ~byte_idx;
               end else if ((rx_code == CODE_RESEND) && (retry_nxt <= RETRY_MAX)) begin
                  go_inh = 1'b1;
               end else begin
                  fail      = 1'b1;
                  fail_code = 2'd3;
               end
            end
         end
         default: ;
      endcase
      // A response arriving in the expiry cycle still counts
      if (to_hit && !((state == S_RESP) && rx_ready)) begin
         fail      = 1'b1;
         fail_code = 2'd1;
         go_inh    = 1'b0;
         go_done   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         inh_cnt     <= '0;
         to_cnt      <= '0;
         retry       <= '0;
         bit_cnt     <= '0;
         byte_idx    <= 1'b0;
         led_q       <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         err_code    <= 2'd0;
         ps2_clk_oe  <= 1'b0;
         ps2_data_oe <= 1'b0;
         rx_rst_n    <= 1'b1;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         if (active) to_cnt <= to_cnt + TW'(1);
         if ((state == S_RESP) && rx_ready && (rx_code == CODE_RESEND)) retry <= retry_nxt;

         if (fail) begin
            state       <= S_ERR;
            err         <= 1'b1;
            err_code    <= fail_code;
            busy        <= 1'b0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            rx_rst_n    <= 1'b1;
         end else if (go_inh) begin
            state       <= S_INHIBIT;
            inh_cnt     <= '0;
            to_cnt      <= '0;
            ps2_clk_oe  <= 1'b1;
            ps2_data_oe <= 1'b0;
            rx_rst_n    <= 1'b0;
            if (state == S_IDLE) begin
               led_q    <= led_val;
               byte_idx <= 1'b0;
               retry    <= '0;
               busy     <= 1'b1;
               err_code <= 2'd0;
            end else if (rx_code == CODE_ACK) begin
               byte_idx <= 1'b1;
               retry    <= '0;
            end
         end else if (go_done) begin
            state <= S_DONE;
            done  <= 1'b1;
         end else begin
            case (state)
               S_INHIBIT: begin
                  to_cnt <= '0;
                  if (inh_cnt == INH_LAST) begin
                     state       <= S_START;
                     ps2_data_oe <= 1'b1;
                  end else begin
                     inh_cnt <= inh_cnt + IW'(1);
                  end
               end
               S_START: begin
                  ps2_clk_oe <= 1'b0;
                  bit_cnt    <= '0;
                  state      <= S_TX;
               end
               S_TX: begin
                  if (clk_fall) begin
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt < 4'd8)
                        ps2_data_oe <= ~tx_byte[bit_cnt[2:0]];
                     else if (bit_cnt == 4'd8)
                        ps2_data_oe <= ~tx_parity;
                     else if (bit_cnt == 4'd9)
                        ps2_data_oe <= 1'b0;
                     else
                        state <= S_REL;
                  end
               end
               S_REL: begin
                  if (clk_s2) begin
                     rx_rst_n <= 1'b1;
                     state    <= S_RESP;
                  end
               end
               S_DONE: begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
               S_ERR:   state <= S_IDLE;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ps2_led_cmd_ctrl.sv
// Bench for ps2_led_cmd_ctrl: behavioural PS/2 device plus a scoreboard of expected bytes and outcomes.
module tb_ps2_led_cmd_ctrl;

   localparam int INH      = 40;
   localparam int TO       = 1500;
   localparam int MAXR     = 3;
   localparam int H        = 10;
   localparam int WAIT_MAX = INH + 600;

   logic       clk = 1'b0;
   logic       rst;
   logic       led_req;
   logic [2:0] led_val;
   logic       busy, done, err;
   logic [1:0] err_code;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       rx_ready;
   logic [9:0] rx_code;
   logic       rx_rst_n;
   logic       dev_clk_low, dev_data_low;
   logic       ps2_clk_line, ps2_data_line;

   assign ps2_clk_line  = ~(ps2_clk_oe  | dev_clk_low);
   assign ps2_data_line = ~(ps2_data_oe | dev_data_low);

   ps2_led_cmd_ctrl #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TO),
      .MAX_RETRY(MAXR)
   ) dut (
      .clk(clk), .rst(rst),
      .led_req(led_req), .led_val(led_val),
      .busy(busy), .done(done), .err(err), .err_code(err_code),
      .ps2_clk_in(ps2_clk_line), .ps2_data_in(ps2_data_line),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe),
      .rx_ready(rx_ready), .rx_code(rx_code), .rx_rst_n(rx_rst_n)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0]      led;
      logic [3:0]      nresp;
      logic [4:0][9:0] resp;
      logic            nack;
      logic            dbl;
      logic            exp_done;
      logic [1:0]      exp_code;
   } vec_t;

   typedef struct packed { logic [7:0] b; logic p; } txe_t;
   typedef struct packed { logic d; logic [1:0] c; } res_t;

   vec_t vecs [8];
   txe_t exp_q [$];
   res_t res_q [$];

   int checks = 0, failures = 0;
   int cyc = 0;
   int done_cnt = 0, err_cnt = 0, resp_cnt = 0, err_cyc = 0, inh_run = 0;
   logic [1:0] last_code = 2'd0;
   logic rx_prev = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [4:0][9:0] mk5(input logic [9:0] a, b, c, d, e);
      logic [4:0][9:0] r;
      r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e;
      return r;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Pulse/phase monitor, sampled away from the active edge
   always @(negedge clk) begin
      if (done === 1'b1) begin
         done_cnt++;
         last_code = err_code;
         chk("busy_at_done", busy, 1);
      end
      if (err === 1'b1) begin
         err_cnt++;
         last_code = err_code;
         err_cyc   = cyc;
         chk("busy_at_err", busy, 0);
      end
      if (rx_rst_n === 1'b1 && rx_prev === 1'b0 && busy === 1'b1) resp_cnt++;
      rx_prev = rx_rst_n;
      if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b0) begin
         inh_run++;
      end else begin
         if (ps2_clk_oe === 1'b1 && ps2_data_oe === 1'b1 && inh_run > 0)
            chk("inhibit_len", inh_run, INH);
         inh_run = 0;
      end
   end

   // Device side of one host-to-device byte; stop_after>0 leaves ps2_clk held low after that clock
   task automatic dev_rx(input bit nack, input int stop_after,
                         output logic [7:0] b, output logic p, output logic s, output bit ok);
      ok = 0; b = '0; p = 0; s = 0;
      for (int i = 0; i < WAIT_MAX && !(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1); i++) @(negedge clk);
      if (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1)) return;
      repeat (H) @(negedge clk);
      for (int c = 1; c <= 11; c++) begin
         dev_clk_low = 1'b1;
         repeat (H) @(negedge clk);
         if (c == stop_after) begin
            ok = 1;
            return;
         end
         dev_clk_low = 1'b0;
         if (c <= 8) b[c-1] = ps2_data_line;
         else if (c == 9) p = ps2_data_line;
         else if (c == 10) begin
            s = ps2_data_line;
            if (!nack) dev_data_low = 1'b1;
         end
         repeat (H) @(negedge clk);
         if (c == 11) dev_data_low = 1'b0;
      end
      ok = 1;
   endtask

   task automatic respond(input logic [9:0] code);
      for (int i = 0; i < WAIT_MAX && rx_rst_n !== 1'b1; i++) @(negedge clk);
      chk("resp_phase_reached", rx_rst_n, 1);
      repeat (3) @(negedge clk);
      rx_code  = code;
      rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
   endtask

   task automatic check_byte();
      logic [7:0] bb; logic pp, ss; bit ok;
      txe_t e;
      dev_rx(1'b0, 0, bb, pp, ss, ok);
      chk("dev_saw_start", ok, 1);
      e = exp_q.pop_front();
      chk("tx_byte", bb, e.b);
      chk("tx_parity", pp, e.p);
      chk("tx_stop", ss, 1);
   endtask

   task automatic wait_outcome(input int base_d, input int base_e);
      res_t r;
      int i;
      for (i = 0; i < TO + WAIT_MAX && done_cnt == base_d && err_cnt == base_e; i++) @(negedge clk);
      repeat (10) @(negedge clk);
      r = res_q.pop_front();
      chk("done_count", done_cnt - base_d, r.d);
      chk("err_count", err_cnt - base_e, !r.d);
      chk("err_code", last_code, r.c);
      chk("busy_idle", busy, 0);
      chk("lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
   endtask

   task automatic run_vec(input vec_t v);
      int nsend, base_d, base_e, base_r;
      logic idx;
      logic [7:0] bb; logic pp, ss; bit ok;
      txe_t e;
      nsend = int'(v.nresp) + int'(v.nack);
      idx = 1'b0;
      for (int k = 0; k < nsend; k++) begin
         bb = idx ? {5'b0, v.led} : 8'hED;
         exp_q.push_back('{bb, ~^bb});
         if (k < int'(v.nresp) && v.resp[k] == 10'h0FA) idx = 1'b1;
      end
      res_q.push_back('{v.exp_done, v.exp_code});
      base_d = done_cnt; base_e = err_cnt; base_r = resp_cnt;
      led_val = v.led;
      led_req = 1'b1;
      @(negedge clk);
      led_req = 1'b0;
      chk("busy_after_req", busy, 1);
      if (v.dbl) begin
         repeat (20) @(negedge clk);
         led_val = 3'b010;
         led_req = 1'b1;
         @(negedge clk);
         led_req = 1'b0;
      end
      for (int k = 0; k < nsend; k++) begin
         dev_rx(v.nack && k == int'(v.nresp), 0, bb, pp, ss, ok);
         chk("dev_saw_start", ok, 1);
         if (!ok) break;
         e = exp_q.pop_front();
         chk("tx_byte", bb, e.b);
         chk("tx_parity", pp, e.p);
         chk("tx_stop", ss, 1);
         if (k < int'(v.nresp)) respond(v.resp[k]);
      end
      wait_outcome(base_d, base_e);
      chk("resp_phases", resp_cnt - base_r, v.nresp);
      repeat (5) @(negedge clk);
      chk("no_queued_req", busy, 0);
      exp_q.delete();
   endtask

   initial begin
      #3000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int t0, base_d, base_e;
      logic [7:0] bb; logic pp, ss; bit ok;

      vecs[0] = '{3'b101, 4'd2, mk5(10'h0FA, 10'h0FA, 0, 0, 0), 1'b0, 1'b0, 1'b1, 2'd0};
      vecs[1] = '{3'b011, 4'd3, mk5(10'h0FE, 10'h0FA, 10'h0FA, 0, 0), 1'b0, 1'b0, 1'b1, 2'd0};
      vecs[2] = '{3'b000, 4'd4, mk5(10'h0FE, 10'h0FE, 10'h0FE, 10'h0FE, 0), 1'b0, 1'b0, 1'b0, 2'd3};
      vecs[3] = '{3'b111, 4'd1, mk5(10'h2FA, 0, 0, 0, 0), 1'b0, 1'b0, 1'b0, 2'd3};
      vecs[4] = '{3'b110, 4'd0, mk5(0, 0, 0, 0, 0), 1'b1, 1'b0, 1'b0, 2'd2};
      vecs[5] = '{3'b001, 4'd2, mk5(10'h0FA, 10'h0AB, 0, 0, 0), 1'b0, 1'b0, 1'b0, 2'd3};
      vecs[6] = '{3'b101, 4'd2, mk5(10'h0FA, 10'h0FA, 0, 0, 0), 1'b0, 1'b1, 1'b1, 2'd0};
      vecs[7] = '{3'b100, 4'd5, mk5(10'h0FE, 10'h0FA, 10'h0FE, 10'h0FE, 10'h0FA), 1'b0, 1'b0, 1'b1, 2'd0};

      rst = 1'b1; led_req = 1'b0; led_val = 3'b000;
      rx_ready = 1'b0; rx_code = '0;
      dev_clk_low = 1'b0; dev_data_low = 1'b0;
      repeat (4) @(negedge clk);
      chk("rst_clk_oe", ps2_clk_oe, 0);
      chk("rst_data_oe", ps2_data_oe, 0);
      chk("rst_rx_rst_n", rx_rst_n, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done_err", {done, err}, 0);
      chk("rst_err_code", err_code, 0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Device never clocks: timeout counted from START entry
      res_q.push_back('{1'b0, 2'd1});
      base_d = done_cnt; base_e = err_cnt;
      led_val = 3'b011; led_req = 1'b1;
      @(negedge clk);
      led_req = 1'b0;
      for (int i = 0; i < WAIT_MAX && ps2_data_oe !== 1'b1; i++) @(negedge clk);
      chk("start_seen", ps2_data_oe, 1);
      t0 = cyc;
      wait_outcome(base_d, base_e);
      chk("timeout_latency", err_cyc - t0, TO);

      // Ack arriving in the very cycle the timeout expires wins
      exp_q.push_back('{8'hED, ~^8'hED});
      exp_q.push_back('{8'h06, ~^8'h06});
      res_q.push_back('{1'b1, 2'd0});
      base_d = done_cnt; base_e = err_cnt;
      led_val = 3'b110; led_req = 1'b1;
      @(negedge clk);
      led_req = 1'b0;
      for (int i = 0; i < WAIT_MAX && ps2_data_oe !== 1'b1; i++) @(negedge clk);
      t0 = cyc;
      check_byte();
      for (int i = 0; i < TO + 10 && cyc < t0 + TO - 1; i++) @(negedge clk);
      chk("race_in_resp", rx_rst_n, 1);
      rx_code = 10'h0FA; rx_ready = 1'b1;
      @(negedge clk);
      rx_ready = 1'b0;
      check_byte();
      respond(10'h0FA);
      wait_outcome(base_d, base_e);

      // Reset while the device holds ps2_clk low during bit 4
      base_d = done_cnt; base_e = err_cnt;
      led_val = 3'b111; led_req = 1'b1;
      @(negedge clk);
      led_req = 1'b0;
      dev_rx(1'b0, 4, bb, pp, ss, ok);
      chk("abort_reached_bit4", ok, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_lines", {ps2_clk_oe, ps2_data_oe}, 0);
      chk("abort_busy", busy, 0);
      chk("abort_rx_rst_n", rx_rst_n, 1);
      rst = 1'b0;
      dev_clk_low = 1'b0;
      repeat (5) @(negedge clk);
      chk("abort_no_pulse", (done_cnt - base_d) + (err_cnt - base_e), 0);
      run_vec(vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
